ldpc_decode_scheduler: RTL and testbench

- Phase/iteration controller sitting directly upstream of the decoder's address-generator counters.
- Drives their count-enable and clear inputs through a full decode:
  - channel-LLR load;
  - repeated check-node (CN) and variable-node (VN) passes;
  - syndrome check.
- Counts iterations, terminates on max_iter (or early on a zero syndrome), and reports done/converged to the top-level controller.

---
 rtl/ldpc_decode_scheduler.sv | 155 +++++++++++++++
 tb/tb_ldpc_decode_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_decode_scheduler.sv
// Phase/iteration controller for an LDPC decoder: sequences LLR load, CN/VN passes and syndrome check.
// Optional early termination on a zero syndrome is enabled by defining LDPC_EARLY_TERM_EN.
module ldpc_decode_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int LOAD_DEPTH = 64,
    parameter int CN_DEPTH   = 32,
    parameter int VN_DEPTH   = 64,
    parameter int PIPE_LAT   = 2,
    parameter int ITER_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] max_iter,
    input  logic                  llr_valid,
    output logic                  llr_ready,
    input  logic                  syndrome_valid,
    input  logic                  syndrome_ok,
    output logic                  ag_en,
    output logic                  ag_clr,
    output logic                  addr_last,
    output logic [2:0]            phase,
    output logic [ITER_WIDTH-1:0] iter_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  converged
);

    // Handshake: an LLR word transfers on a cycle where llr_valid && llr_ready are both high.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CN    = 3'd2,
        S_VN    = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LOAD_LAST  = ADDR_WIDTH'(LOAD_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] CN_LAST    = ADDR_WIDTH'(CN_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] VN_LAST    = ADDR_WIDTH'(VN_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DRAIN_W-1:0]      drain_q, drain_d;
    logic                    draining_q, draining_d;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d;
    logic [ITER_WIDTH-1:0]   limit_q, limit_d;
    logic                    conv_q, conv_d;
    logic [ADDR_WIDTH-1:0]   last_idx;
    logic                    phase_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drain_q    <= '0;
            draining_q <= 1'b0;
            iter_q     <= '0;
            limit_q    <= '0;
            conv_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            draining_q <= draining_d;
            iter_q     <= iter_d;
            limit_q    <= limit_d;
            conv_q     <= conv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        draining_d = draining_q;
        iter_d     = iter_q;
        limit_d    = limit_q;
        conv_d     = conv_q;
        ag_en      = 1'b0;
        llr_ready  = 1'b0;
        phase_end  = 1'b0;

        case (state_q)
            S_LOAD:  last_idx = LOAD_LAST;
            S_CN:    last_idx = CN_LAST;
            S_VN:    last_idx = VN_LAST;
            default: last_idx = '0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    limit_d    = (max_iter == '0) ? ITER_WIDTH'(1) : max_iter;
                    iter_d     = '0;
                    conv_d     = 1'b0;
                    cnt_d      = '0;
                    drain_d    = '0;
                    draining_d = 1'b0;
                end
            end
            S_LOAD, S_CN, S_VN: begin
                if (draining_q) begin
                    if (drain_q == DRAIN_LAST) phase_end = 1'b1;
                    else                       drain_d   = drain_q + 1'b1;
                end else begin
                    llr_ready = (state_q == S_LOAD);
                    ag_en     = (state_q == S_LOAD) ? llr_valid : 1'b1;
                    // Counter holds at the last index during drain; it never wraps.
                    if (ag_en) begin
                        if (cnt_q == last_idx) begin
                            if (PIPE_LAT == 0) phase_end  = 1'b1;
                            else               draining_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                if (phase_end) begin
                    cnt_d      = '0;
                    drain_d    = '0;
                    draining_d = 1'b0;
                    state_d    = (state_q == S_LOAD) ? S_CN :
                                 (state_q == S_CN)   ? S_VN : S_CHECK;
                end
            end
            S_CHECK: begin
                if (syndrome_valid) begin
                    iter_d = (iter_q < limit_q) ? iter_q + 1'b1 : iter_q;
                    conv_d = syndrome_ok;
`ifdef LDPC_EARLY_TERM_EN
                    state_d = ((iter_d == limit_q) || syndrome_ok) ? S_DONE : S_CN;
`else
                    state_d = (iter_d == limit_q) ? S_DONE : S_CN;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ag_clr    = ag_en && (cnt_q == '0);
    assign addr_last = ag_en && (cnt_q == last_idx);
    assign phase     = state_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign iter_cnt  = iter_q;
    assign converged = conv_q;

endmodule

// File: tb/tb_ldpc_decode_scheduler.sv
// Bench for ldpc_decode_scheduler: a per-cycle expected trace is generated from the phase rules and replayed.
module tb_ldpc_decode_scheduler;

    localparam int AW = 8;
    localparam int LD = 4;
    localparam int CD = 3;
    localparam int VD = 5;
    localparam int PL = 2;
    localparam int IW = 5;
`ifdef LDPC_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, llr_valid, syndrome_valid, syndrome_ok;
    logic [IW-1:0] max_iter;
    logic          llr_ready, ag_en, ag_clr, addr_last, busy, done, converged;
    logic [2:0]    phase;
    logic [IW-1:0] iter_cnt;

    always #5 clk = ~clk;

    ldpc_decode_scheduler #(
        .ADDR_WIDTH(AW), .LOAD_DEPTH(LD), .CN_DEPTH(CD), .VN_DEPTH(VD),
        .PIPE_LAT(PL), .ITER_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .max_iter(max_iter),
        .llr_valid(llr_valid), .llr_ready(llr_ready),
        .syndrome_valid(syndrome_valid), .syndrome_ok(syndrome_ok),
        .ag_en(ag_en), .ag_clr(ag_clr), .addr_last(addr_last), .phase(phase),
        .iter_cnt(iter_cnt), .busy(busy), .done(done), .converged(converged)
    );

    // One cycle of stimulus plus the outputs the phase rules require on that cycle.
    typedef struct packed {
        logic          start;
        logic [IW-1:0] mi;
        logic          lv, sv, so;
        logic [2:0]    ph;
        logic          en, clr, last, rdy, bsy, dn;
        logic [IW-1:0] iter;
        logic          conv;
    } rec_t;

    rec_t          trace_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] exp_iter = '0;
    logic          exp_conv = 1'b0;
    int            en_cnt, clr_cnt, last_cnt, done_cnt, load_cyc, check_cyc;

    function automatic logic [14:0] pack_exp(rec_t r);
        return {r.ph, r.en, r.clr, r.last, r.rdy, r.bsy, r.dn, r.iter, r.conv};
    endfunction

    task automatic push(input logic [2:0] ph, input logic lv, input logic sv, input logic so,
                        input logic en, input logic clr, input logic last, input logic rdy,
                        input logic dn);
        rec_t r;
        r.start = (ph != 3'd0) && ($urandom_range(0, 5) == 0);
        r.mi    = IW'($urandom_range(0, 31));
        r.lv = lv; r.sv = sv; r.so = so;
        r.ph = ph; r.en = en; r.clr = clr; r.last = last; r.rdy = rdy;
        r.bsy = (ph != 3'd0); r.dn = dn; r.iter = exp_iter; r.conv = exp_conv;
        trace_q.push_back(r);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // llr_mode: 0 held high, 1 toggling 1,0,..., 2 random. ok_at: iteration with ok=1 (0 none, -1 random).
    task automatic build_decode(input int mi, input int llr_mode, input int dmin, input int dmax,
                                input int ok_at);
        int   lim, acc, k, d, it;
        logic v, ok;
        rec_t r;
        lim = (mi == 0) ? 1 : mi;
        r = '0;
        r.start = 1'b1; r.mi = IW'(mi); r.lv = rbit(); r.sv = rbit(); r.so = rbit();
        r.iter = exp_iter; r.conv = exp_conv;
        trace_q.push_back(r);
        exp_iter = '0;
        exp_conv = 1'b0;
        acc = 0; k = 0;
        while (acc < LD) begin
            case (llr_mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = rbit();
            endcase
            push(3'd1, v, rbit(), rbit(), v, v && acc == 0, v && acc == LD - 1, 1'b1, 1'b0);
            acc += int'(v);
            k++;
        end
        for (int j = 0; j < PL; j++) push(3'd1, rbit(), rbit(), rbit(), 0, 0, 0, 0, 0);
        it = 0;
        while (1) begin
            it++;
            for (int j = 0; j < CD; j++) push(3'd2, rbit(), rbit(), rbit(), 1, j == 0, j == CD - 1, 0, 0);
            for (int j = 0; j < PL; j++) push(3'd2, rbit(), rbit(), rbit(), 0, 0, 0, 0, 0);
            for (int j = 0; j < VD; j++) push(3'd3, rbit(), rbit(), rbit(), 1, j == 0, j == VD - 1, 0, 0);
            for (int j = 0; j < PL; j++) push(3'd3, rbit(), rbit(), rbit(), 0, 0, 0, 0, 0);
            d = $urandom_range(dmin, dmax);
            for (int j = 0; j < d; j++) push(3'd4, rbit(), 1'b0, rbit(), 0, 0, 0, 0, 0);
            ok = (ok_at < 0) ? rbit() : (it == ok_at);
            push(3'd4, rbit(), 1'b1, ok, 0, 0, 0, 0, 0);
            exp_iter = exp_iter + 1'b1;
            exp_conv = ok;
            if (it == lim || (EARLY && ok)) break;
        end
        push(3'd5, rbit(), rbit(), rbit(), 0, 0, 0, 0, 1);
        push(3'd0, rbit(), rbit(), rbit(), 0, 0, 0, 0, 0);
    endtask

    task automatic clear_counts();
        en_cnt = 0; clr_cnt = 0; last_cnt = 0; done_cnt = 0; load_cyc = 0; check_cyc = 0;
    endtask

    task automatic run_trace(input bit abort_vn);
        rec_t        r;
        logic [14:0] exp_v, act_v;
        int          vn_k;
        vn_k = 0;
        while (trace_q.size() > 0) begin
            r = trace_q.pop_front();
            @(negedge clk);
            start = r.start; max_iter = r.mi; llr_valid = r.lv;
            syndrome_valid = r.sv; syndrome_ok = r.so;
            #1;
            exp_v = pack_exp(r);
            act_v = {phase, ag_en, ag_clr, addr_last, llr_ready, busy, done, iter_cnt, converged};
            checks++;
            assert (act_v === exp_v) else begin
                errors++;
                $error("FAIL cycle_trace phase_exp=%0d: observed %h expected %h", r.ph, act_v, exp_v);
            end
            en_cnt += int'(ag_en); clr_cnt += int'(ag_clr); last_cnt += int'(addr_last);
            done_cnt += int'(done);
            load_cyc += int'(phase == 3'd1); check_cyc += int'(phase == 3'd4);
            if (abort_vn && r.ph == 3'd3 && r.en) begin
                vn_k++;
                if (vn_k == 3) begin
                    trace_q.delete();
                    break;
                end
            end
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        logic [14:0] act_v;
        act_v = {phase, ag_en, ag_clr, addr_last, llr_ready, busy, done, iter_cnt, converged};
        checks++;
        assert (act_v === 15'h0) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act_v, 15'h0);
        end
    endtask

    initial begin
        int mi_r;
        reset = 1'b1; start = 1'b1; max_iter = '0; llr_valid = 1'b0;
        syndrome_valid = 1'b0; syndrome_ok = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_idle("reset_state");
        reset = 1'b0; start = 1'b0;

        // Two full iterations, LLRs always present, syndrome never satisfied.
        clear_counts();
        build_decode(2, 0, 0, 0, 0);
        run_trace(1'b0);
        check_int("a_ag_en_pulses", en_cnt, 20);
        check_int("a_ag_clr_pulses", clr_cnt, 5);
        check_int("a_addr_last_pulses", last_cnt, 5);
        check_int("a_done_pulses", done_cnt, 1);
        check_int("a_iter_cnt", int'(iter_cnt), 2);
        check_int("a_converged", int'(converged), 0);

        // Syndrome satisfied on the second check of a five-iteration limit.
        clear_counts();
        build_decode(5, 2, 0, 3, 2);
        run_trace(1'b0);
        check_int("b_iter_cnt", int'(iter_cnt), EARLY ? 2 : 5);
        check_int("b_converged", int'(converged), EARLY ? 1 : 0);
        check_int("b_ag_en_pulses", en_cnt, LD + (EARLY ? 2 : 5) * (CD + VD));

        // Toggling llr_valid stretches LOAD to 7 issue-phase cycles plus drain.
        clear_counts();
        build_decode(1, 1, 0, 0, -1);
        run_trace(1'b0);
        check_int("c_load_cycles", load_cyc, 7 + PL);

        // Reset in the middle of a VN pass.
        clear_counts();
        build_decode(3, 2, 0, 2, 0);
        run_trace(1'b1);
        @(negedge clk);
        reset = 1'b1; start = 1'b0; llr_valid = 1'b0; syndrome_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("reset_mid_vn");
        exp_iter = '0;
        exp_conv = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            check_idle("post_reset_idle");
        end

        // max_iter=0 runs one iteration; random start pulses while busy are ignored.
        clear_counts();
        build_decode(0, 0, 0, 1, -1);
        run_trace(1'b0);
        check_int("e_iter_cnt", int'(iter_cnt), 1);
        check_int("e_ag_en_pulses", en_cnt, LD + CD + VD);
        check_int("e_done_pulses", done_cnt, 1);

        // Syndrome withheld for ten cycles.
        clear_counts();
        build_decode(1, 0, 10, 10, 0);
        run_trace(1'b0);
        check_int("f_check_cycles", check_cyc, 11);

        // Random decodes.
        for (int n = 0; n < 6; n++) begin
            clear_counts();
            mi_r = $urandom_range(0, 4);
            build_decode(mi_r, 2, 0, 4, -1);
            run_trace(1'b0);
            check_int("r_done_pulses", done_cnt, 1);
            check_int("r_ag_clr_pulses", clr_cnt, 1 + 2 * int'(iter_cnt));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
